// File: rtl/spi_master_ctrl.sv
// SPI initiator: serialises one 10-bit command per frame on MOSI/SS_n and captures a read byte from MISO.
// Optional SPI_MASTER_AUTO_READ_EN: a cmd-10 frame is automatically followed by a cmd-11 frame.
module spi_master_ctrl #(
   parameter int RD_WAIT = 2,
   parameter int GAP_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] tx_word,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       MISO,
   output logic       MOSI,
   output logic       SS_n
);

   localparam logic [3:0] SHIFT_LAST = 4'd9;
   localparam logic [3:0] RECV_LAST  = 4'd7;
   localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
   localparam logic [3:0] GAP_LAST   = 4'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_CMD   = 3'd2,
      S_SHIFT = 3'd3,
      S_WAIT  = 3'd4,
      S_RECV  = 3'd5,
      S_GAP   = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] sh_q, sh_d;
   logic [7:0] rx_q, rx_d;
   logic       rd_cmd_q, rd_cmd_d;
   logic       ss_n_q, ss_n_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rd_valid_q, rd_valid_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       enter_gap_s;
   logic       auto_hold_s;

`ifdef SPI_MASTER_AUTO_READ_EN
   logic       auto_pend_q, auto_pend_d;
   assign auto_hold_s = auto_pend_q;
`else
   assign auto_hold_s = 1'b0;
`endif

   // Per-state counters stop at all-ones instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      sat_inc = (v == 4'hF) ? v : v + 4'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      rx_d        = rx_q;
      rd_cmd_d    = rd_cmd_q;
      ss_n_d      = ss_n_q;
      mosi_d      = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
      enter_gap_s = 1'b0;
`ifdef SPI_MASTER_AUTO_READ_EN
      auto_pend_d = auto_pend_q;
`endif
      // Outputs are computed for the state being entered so pins line up with the state register.
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_LEAD;
               sh_d     = tx_word;
               rd_cmd_d = (tx_word[9:8] == 2'b11);
               busy_d   = 1'b1;
               ss_n_d   = 1'b0;
               cnt_d    = 4'd0;
`ifdef SPI_MASTER_AUTO_READ_EN
               auto_pend_d = (tx_word[9:8] == 2'b10);
`endif
            end else begin
               ss_n_d = 1'b1;
            end
         end
         S_LEAD: begin
            state_d = S_CMD;
            mosi_d  = sh_q[9];
         end
         S_CMD: begin
            state_d = S_SHIFT;
            mosi_d  = sh_q[9];
            cnt_d   = 4'd0;
         end
         S_SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               if (rd_cmd_q) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'd0;
               end else begin
                  enter_gap_s = 1'b1;
               end
            end else begin
               cnt_d  = sat_inc(cnt_q);
               sh_d   = {sh_q[8:0], 1'b0};
               mosi_d = sh_q[8];
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = S_RECV;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         S_RECV: begin
            rx_d = {rx_q[6:0], MISO};
            if (cnt_q == RECV_LAST) begin
               enter_gap_s = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = 4'd0;
               if (auto_hold_s) begin
                  // Chain the read-data frame without releasing busy.
                  state_d  = S_LEAD;
                  sh_d     = 10'b11_0000_0000;
                  rd_cmd_d = 1'b1;
                  ss_n_d   = 1'b0;
`ifdef SPI_MASTER_AUTO_READ_EN
                  auto_pend_d = 1'b0;
`endif
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d  = sat_inc(cnt_q);
               done_d = (sat_inc(cnt_q) == GAP_LAST) && !auto_hold_s;
            end
         end
         default: begin
            state_d = S_IDLE;
            ss_n_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
         end
      endcase

      if (enter_gap_s) begin
         state_d = S_GAP;
         ss_n_d  = 1'b1;
         cnt_d   = 4'd0;
         done_d  = (GAP_LAST == 4'd0) && !auto_hold_s;
      end else begin
         state_d = state_d;
      end

      if (done_d && rd_cmd_q) begin
         rd_valid_d = 1'b1;
         rd_data_d  = rx_d;
      end else begin
         rd_valid_d = 1'b0;
      end
   end

   // State and registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         sh_q       <= 10'd0;
         rx_q       <= 8'd0;
         rd_cmd_q   <= 1'b0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
`ifdef SPI_MASTER_AUTO_READ_EN
         auto_pend_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         rx_q       <= rx_d;
         rd_cmd_q   <= rd_cmd_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
`ifdef SPI_MASTER_AUTO_READ_EN
         auto_pend_q <= auto_pend_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign MOSI     = mosi_q;
   assign SS_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: table of commands against a behavioural SPI-slave RAM,
// scoreboarded done/rd_data results and per-frame MOSI stream checks.
module tb_spi_master_ctrl;

   localparam int RD_WAIT = 2;
   localparam int RECV0   = 12 + RD_WAIT;
`ifdef SPI_MASTER_AUTO_READ_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] tx_word;
   logic       busy, done, rd_valid, MOSI, SS_n;
   logic [7:0] rd_data;
   logic       MISO = 1'b0;

   spi_master_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .tx_word(tx_word),
      .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
      .MISO(MISO), .MOSI(MOSI), .SS_n(SS_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] word;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_lat;
      logic [7:0] auto_data;
   } vec_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      int         lat;
      int         acc;
   } sb_t;

   typedef struct {
      int          len;
      logic [11:0] bits;
   } fr_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   sb_t  sb_q[$];
   fr_t  fr_q[$];
   bit   abort_ok = 1'b0;

   logic [7:0]  ram [256];
   logic [7:0]  saddr;
   logic [11:0] sbits = 12'd0;
   int          scnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] mosi_bits(input logic [9:0] w);
      return {1'b0, w[9], w};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SPI-slave RAM; also checks each completed frame against the expected MOSI stream.
   always @(negedge clk) begin
      if (SS_n == 1'b0) begin
         if (scnt < 12) sbits[11 - scnt] = MOSI;
         if (scnt >= RECV0 && scnt < RECV0 + 8 && sbits[9:8] == 2'b11)
            MISO = ram[saddr][7 - (scnt - RECV0)];
         else
            MISO = 1'b0;
         scnt++;
      end else begin
         MISO = 1'b0;
         if (scnt > 0 && !abort_ok) begin
            if (fr_q.size() == 0) begin
               chk("frame_unexpected_len", scnt, 0);
            end else begin
               fr_t f;
               f = fr_q.pop_front();
               chk("frame_len", scnt, f.len);
               chk("frame_mosi", {20'd0, sbits}, {20'd0, f.bits});
            end
         end
         if (scnt >= 12) begin
            case (sbits[9:8])
               2'b00:   saddr = sbits[7:0];
               2'b01:   ram[saddr] = sbits[7:0];
               2'b10:   saddr = sbits[7:0];
               default: ;
            endcase
         end
         scnt = 0;
      end
   end

   // Scoreboard: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rd_valid && !done) chk("rd_valid_without_done", rd_valid, 0);
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("done_unexpected", done, 0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("done_latency", cyc - e.acc + 1, e.lat);
            chk("rd_valid", rd_valid, e.v);
            chk("rd_data", rd_data, e.d);
         end
      end
   end

   task automatic send(input logic [9:0] w, input logic ev, input logic [7:0] ed,
                       input int el, input bit push);
      sb_t e;
      fr_t f;
      @(negedge clk);
      start   = 1'b1;
      tx_word = w;
      if (push) begin
         e.v = ev; e.d = ed; e.lat = el; e.acc = cyc + 1;
         sb_q.push_back(e);
         f.bits = mosi_bits(w);
         f.len  = (w[9:8] == 2'b11) ? 12 + RD_WAIT + 8 : 12;
         fr_q.push_back(f);
         if (AUTO && w[9:8] == 2'b10) begin
            f.bits = mosi_bits(10'b11_0000_0000);
            f.len  = 12 + RD_WAIT + 8;
            fr_q.push_back(f);
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("accept_ss_n", SS_n, 0);
      chk("accept_busy", busy, 1);
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && sb_q.size() == 0 && fr_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_timeout"}, ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      vecs[0] = '{10'b00_1111_1111, 1'b0, 8'h00, 13, 8'h00};
      vecs[1] = '{10'b01_1010_1010, 1'b0, 8'h00, 13, 8'h00};
      vecs[2] = '{10'b10_0000_0011, 1'b0, 8'h00, 13, 8'hB2};
      vecs[3] = '{10'b11_0000_0000, 1'b1, 8'hB2, 23, 8'h00};
      vecs[4] = '{10'b00_0000_0101, 1'b0, 8'hB2, 13, 8'h00};
      vecs[5] = '{10'b01_0101_1100, 1'b0, 8'hB2, 13, 8'h00};
      vecs[6] = '{10'b10_0000_0101, 1'b0, 8'hB2, 13, 8'h5C};
      vecs[7] = '{10'b11_0000_0000, 1'b1, 8'h5C, 23, 8'h00};
      vecs[8] = '{10'b10_1111_1111, 1'b0, 8'h5C, 13, 8'hAA};
      vecs[9] = '{10'b11_0000_0000, 1'b1, 8'hAA, 23, 8'h00};

      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[3] = 8'hB2;
      saddr  = 8'h00;

      // Reset held two cycles with start high: nothing may start.
      rst = 1'b1; start = 1'b1; tx_word = 10'h3FF;
      repeat (2) @(negedge clk);
      chk("reset_ss_n", SS_n, 1);
      chk("reset_mosi", MOSI, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_data", rd_data, 8'h00);
      rst = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_ss_n", SS_n, 1);
      chk("post_reset_busy", busy, 0);

      for (int i = 0; i < 10; i++) begin
         if (AUTO && vecs[i].word[9:8] == 2'b10)
            send(vecs[i].word, 1'b1, vecs[i].auto_data, 36, 1'b1);
         else
            send(vecs[i].word, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_lat, 1'b1);
         wait_idle("vec");
      end
      chk("ram255_written", ram[255], 8'hAA);

      // Start pulsed mid-frame must be ignored.
      send(10'b00_0000_0011, 1'b0, 8'hAA, 13, 1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1; tx_word = 10'b01_1111_1111;
      @(negedge clk);
      start = 1'b0;
      wait_idle("busy_start");
      chk("busy_start_ram255", ram[255], 8'hAA);
      chk("busy_start_ram3", ram[3], 8'hB2);

      // Reset during SHIFT bit 4 abandons the frame silently.
      abort_ok = 1'b1;
      send(10'b01_0000_1111, 1'b0, 8'h00, 0, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midreset_ss_n", SS_n, 1);
      chk("midreset_busy", busy, 0);
      chk("midreset_done", done, 0);
      chk("midreset_rd_data", rd_data, 8'h00);
      repeat (20) @(negedge clk);
      chk("midreset_idle_ss_n", SS_n, 1);
      abort_ok = 1'b0;

      send(10'b11_0000_0000, 1'b1, 8'hB2, 23, 1'b1);
      wait_idle("after_reset");
      chk("ram3_intact", ram[3], 8'hB2);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
